display_readout: RTL and testbench

- Reads out the 1-bit result map that the CNN pattern-detection `main` exposes on its display port, once `main` reports done with stage5.
- Drives that port as its initiator: ena_display, read_display and addr_display out, dout_display back in.
- Packs the pixel bits LSB-first into bytes and streams them on a valid/ready byte interface toward a host link.
- Counts set (pattern-hit) pixels for the frame.

---
 rtl/display_readout.sv | 146 ++++++++++++++
 tb/tb_display_readout.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_readout.sv
// display_readout: reads the 1-bit result map from the pattern-detection core's
// display port and packs the pixels LSB-first into bytes. The bytes go out on a
// valid/ready stream. The block also counts the set pixels of the frame.
module display_readout #(
    parameter int ADDR_W  = 17,
    parameter int NUM_PIX = 76800,
    parameter int CNT_W   = 17
) (
    input  logic              clk,
    input  logic              rst,            // asynchronous, active low
    input  logic              start,
    input  logic              src_done,
    input  logic              src_stage5,
    output logic              ena_display,
    output logic              read_display,
    output logic [ADDR_W-1:0] addr_display,
    input  logic              dout_display,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              complete,
    output logic [CNT_W-1:0]  hit_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_CAP,
        S_SEND,
        S_FIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;       // address issued most recently
    logic [3:0]        bit_idx_q, bit_idx_d; // reads issued for the current byte
    logic [7:0]        byte_q, byte_d;
    logic [CNT_W-1:0]  hit_q, hit_d;
    logic [2:0]        cap_pos;
    logic              capture;
    logic              at_last;

    // The bit arriving now belongs to the read issued one cycle earlier.
    assign cap_pos = 3'(bit_idx_q - 4'd1);
    assign at_last = (addr_q == LAST_ADDR);

    // Next-state, datapath updates and port strobes for the readout sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves a value unassigned; an unassigned path would infer a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        bit_idx_d    = bit_idx_q;
        byte_d       = byte_q;
        hit_d        = hit_q;
        capture      = 1'b0;
        ena_display  = 1'b0;
        read_display = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        complete     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && src_done && src_stage5) begin
                    state_d   = S_FILL;
                    addr_d    = '0;
                    bit_idx_d = '0;
                    byte_d    = '0;
                    hit_d     = '0;
                end
            end
            S_FILL: begin
                ena_display  = 1'b1;
                read_display = 1'b1;
                capture      = (bit_idx_q != 4'd0);
                bit_idx_d    = bit_idx_q + 4'd1;
                // Hold the address on the final read so it never passes the frame end.
                if (bit_idx_q == 4'd7 || at_last) begin
                    state_d = S_CAP;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_CAP: begin
                capture = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_last  = at_last;
                if (out_ready) begin
                    if (at_last) begin
                        state_d = S_FIN;
                    end else begin
                        state_d   = S_FILL;
                        addr_d    = addr_q + ADDR_W'(1);
                        bit_idx_d = '0;
                        byte_d    = '0;
                    end
                end
            end
            S_FIN: begin
                complete = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Unfilled bits of a short final byte stay at the cleared value of 0.
        if (capture) begin
            byte_d[cap_pos] = dout_display;
            if (dout_display) begin
                hit_d = hit_q + CNT_W'(1);
            end
        end
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            bit_idx_q <= '0;
            byte_q    <= '0;
            hit_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q   <= state_d;
            addr_q    <= addr_d;
            bit_idx_q <= bit_idx_d;
            byte_q    <= byte_d;
            hit_q     <= hit_d;
        end
    end

    assign addr_display = addr_q;
    assign out_data     = byte_q;
    assign hit_count    = hit_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_display_readout.sv
// Self-checking bench for display_readout. There are three instances with
// NUM_PIX = 20, 16 and 1. A pixel-memory model answers the display port. A
// reference model predicts bytes, last flags, hit counts and read addresses
// from the pixel array.
module tb_display_readout;

    localparam int NI = 3;

    function automatic int npix_of(input int k);
        return (k == 0) ? 20 : (k == 1) ? 16 : 1;
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        src_done, src_stage5;
    logic        start    [NI];
    logic        ena      [NI];
    logic        rd       [NI];
    logic        dout     [NI];
    logic        valid    [NI];
    logic        ready    [NI];
    logic        last     [NI];
    logic        busy     [NI];
    logic        complete [NI];
    logic [16:0] addr     [NI];
    logic [7:0]  data     [NI];
    logic [16:0] hits     [NI];

    logic        pix [NI][32];
    bit          rand_ready [NI];
    bit          hold_ready [NI];

    // Monitor logs
    logic [7:0]  blog  [NI][8];
    logic        blast [NI][8];
    int          bcnt  [NI];
    int          rlog  [NI][64];
    int          rcnt  [NI];
    int          ccnt  [NI];
    int          viol  [NI];

    int checks;
    int errors;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        display_readout #(
            .ADDR_W (17),
            .NUM_PIX(npix_of(g)),
            .CNT_W  (17)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start[g]),
            .src_done    (src_done),
            .src_stage5  (src_stage5),
            .ena_display (ena[g]),
            .read_display(rd[g]),
            .addr_display(addr[g]),
            .dout_display(dout[g]),
            .out_data    (data[g]),
            .out_valid   (valid[g]),
            .out_ready   (ready[g]),
            .out_last    (last[g]),
            .busy        (busy[g]),
            .complete    (complete[g]),
            .hit_count   (hits[g])
        );
    end

    // Display memory: a pixel appears one cycle after its read, garbage otherwise.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            dout[k] <= (ena[k] && rd[k]) ? pix[k][addr[k][4:0]] : 1'($urandom);
        end
    end

    // Sink ready: always 1 or random, unless a test holds it.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NI; k++) begin
            if (!hold_ready[k]) ready[k] = rand_ready[k] ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Log accepted bytes, issued reads, protocol violations and complete pulses.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            for (int k = 0; k < NI; k++) begin
                if (valid[k] && ready[k] && bcnt[k] < 8) begin
                    blog[k][bcnt[k]]  = data[k];
                    blast[k][bcnt[k]] = last[k];
                    bcnt[k]++;
                end
                if (ena[k] && rcnt[k] < 64) begin
                    rlog[k][rcnt[k]] = int'(addr[k]);
                    rcnt[k]++;
                end
                if ((ena[k] && valid[k]) || (ena[k] !== rd[k])) viol[k]++;
                if (complete[k]) ccnt[k]++;
            end
        end
    end

    function automatic logic [7:0] exp_byte(input int k, input int b);
        logic [7:0] e;
        e = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (8 * b + i < npix_of(k)) e[i] = pix[k][8 * b + i];
        end
        return e;
    endfunction

    task automatic clear_logs(input int k);
        bcnt[k] = 0;
        rcnt[k] = 0;
        ccnt[k] = 0;
        viol[k] = 0;
    endtask

    // mode 0 random, 1 all ones, 2 all zeros, 3 pixel = addr[0]
    task automatic set_pix(input int k, input int mode);
        for (int p = 0; p < 32; p++) begin
            case (mode)
                0:       pix[k][p] = 1'($urandom);
                1:       pix[k][p] = 1'b1;
                2:       pix[k][p] = 1'b0;
                default: pix[k][p] = 1'(p & 1);
            endcase
        end
    endtask

    task automatic check_outputs_zero(input int k, input string tag);
        checks++;
        if ({ena[k], rd[k], valid[k], last[k], busy[k], complete[k]} !== 6'b0) begin
            errors++;
            $display("FAIL %s strobes got %b want 000000", tag,
                     {ena[k], rd[k], valid[k], last[k], busy[k], complete[k]});
        end
        checks++;
        if (addr[k] !== 17'd0 || data[k] !== 8'd0 || hits[k] !== 17'd0) begin
            errors++;
            $display("FAIL %s addr/data/hits got %0d/%h/%0d want 0/00/0", tag, addr[k], data[k], hits[k]);
        end
    endtask

    task automatic begin_frame(input int k, input string tag);
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        src_done   = 1'b1;
        src_stage5 = 1'b1;
        start[k]   = 1'b1;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (busy[k]) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s start_timeout busy got 0 want 1", tag);
        end
        @(posedge clk); #1;
        start[k] = 1'b0;
    endtask

    task automatic wait_complete(input int k, input string tag);
        for (int n = 0; n < 3000 && ccnt[k] == 0; n++) @(posedge clk);
        checks++;
        if (ccnt[k] == 0) begin
            errors++;
            $display("FAIL %s complete_timeout got 0 pulses want 1", tag);
        end
    endtask

    task automatic run_frame(input int k, input string tag);
        clear_logs(k);
        begin_frame(k, tag);
        wait_complete(k, tag);
        repeat (3) @(posedge clk);
    endtask

    task automatic check_frame(input int k, input string tag);
        int np, nb, eh, bad;
        np  = npix_of(k);
        nb  = (np + 7) / 8;
        eh  = 0;
        bad = -1;
        for (int p = 0; p < np; p++) eh += int'(pix[k][p]);
        checks++;
        if (bcnt[k] != nb) begin
            errors++;
            $display("FAIL %s byte_count got %0d want %0d", tag, bcnt[k], nb);
        end
        for (int b = 0; b < nb && b < bcnt[k]; b++) begin
            checks++;
            if (blog[k][b] !== exp_byte(k, b)) begin
                errors++;
                $display("FAIL %s byte%0d got %h want %h", tag, b, blog[k][b], exp_byte(k, b));
            end
            checks++;
            if (blast[k][b] !== (b == nb - 1)) begin
                errors++;
                $display("FAIL %s last%0d got %b want %b", tag, b, blast[k][b], (b == nb - 1));
            end
        end
        checks++;
        if (hits[k] !== 17'(eh)) begin
            errors++;
            $display("FAIL %s hit_count got %0d want %0d", tag, hits[k], eh);
        end
        checks++;
        if (ccnt[k] != 1) begin
            errors++;
            $display("FAIL %s complete_pulses got %0d want 1", tag, ccnt[k]);
        end
        checks++;
        if (rcnt[k] != np) begin
            errors++;
            $display("FAIL %s read_count got %0d want %0d", tag, rcnt[k], np);
        end
        for (int i = 0; i < rcnt[k]; i++) begin
            if (rlog[k][i] != i && bad < 0) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s read_order read%0d got addr %0d want %0d", tag, bad, rlog[k][bad], bad);
        end
        checks++;
        if (viol[k] != 0) begin
            errors++;
            $display("FAIL %s port_violations got %0d want 0", tag, viol[k]);
        end
    endtask

    task automatic test_reset;
        #100;
        for (int k = 0; k < NI; k++) check_outputs_zero(k, "reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic;
        set_pix(0, 3);
        rand_ready[0] = 1'b0;
        run_frame(0, "basic");
        check_frame(0, "basic");
        checks++;
        if (blog[0][0] !== 8'hAA || blog[0][1] !== 8'hAA || blog[0][2] !== 8'h0A) begin
            errors++;
            $display("FAIL basic_literal got %h %h %h want aa aa 0a", blog[0][0], blog[0][1], blog[0][2]);
        end
        checks++;
        if (hits[0] !== 17'd10) begin
            errors++;
            $display("FAIL basic_hits got %0d want 10", hits[0]);
        end
    endtask

    task automatic test_gating;
        int busy_seen;
        busy_seen = 0;
        set_pix(0, 0);
        clear_logs(0);
        @(posedge clk); #1;
        src_done   = 1'b1;
        src_stage5 = 1'b0;
        start[0]   = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (busy[0] || ena[0]) busy_seen++;
        end
        checks++;
        if (busy_seen != 0 || rcnt[0] != 0) begin
            errors++;
            $display("FAIL gating busy_cycles got %0d reads %0d want 0 0", busy_seen, rcnt[0]);
        end
        @(posedge clk); #1;
        src_stage5 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ena[0] !== 1'b1 || addr[0] !== 17'd0) begin
            errors++;
            $display("FAIL gating_first_read got ena %b addr %0d want 1 0", ena[0], addr[0]);
        end
        start[0] = 1'b0;
        wait_complete(0, "gating");
        repeat (3) @(posedge clk);
        check_frame(0, "gating");
    endtask

    task automatic test_backpressure;
        logic [7:0] held;
        int unstable;
        bit seen;
        unstable = 0;
        seen     = 1'b0;
        set_pix(0, 0);
        clear_logs(0);
        hold_ready[0] = 1'b1;
        ready[0]      = 1'b0;
        begin_frame(0, "backpressure");
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (valid[0]) seen = 1'b1;
        end
        held = data[0];
        checks++;
        if (!seen || held !== exp_byte(0, 0)) begin
            errors++;
            $display("FAIL backpressure_byte0 got valid %b data %h want 1 %h", seen, held, exp_byte(0, 0));
        end
        repeat (7) begin
            @(negedge clk);
            if (data[0] !== held || ena[0] !== 1'b0 || valid[0] !== 1'b1) unstable++;
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL backpressure_stable got %0d bad cycles want 0", unstable);
        end
        @(posedge clk); #1;
        rand_ready[0] = 1'b0;
        hold_ready[0] = 1'b0;
        ready[0]      = 1'b1;
        wait_complete(0, "backpressure");
        repeat (3) @(posedge clk);
        check_frame(0, "backpressure");
    endtask

    task automatic test_ones_zeros;
        rand_ready[1] = 1'b1;
        set_pix(1, 1);
        run_frame(1, "all_ones");
        check_frame(1, "all_ones");
        checks++;
        if (blog[1][0] !== 8'hFF || blog[1][1] !== 8'hFF || hits[1] !== 17'd16) begin
            errors++;
            $display("FAIL all_ones_literal got %h %h hits %0d want ff ff 16", blog[1][0], blog[1][1], hits[1]);
        end
        set_pix(1, 2);
        run_frame(1, "all_zeros");
        check_frame(1, "all_zeros");
        checks++;
        if (hits[1] !== 17'd0) begin
            errors++;
            $display("FAIL all_zeros_hits got %0d want 0", hits[1]);
        end
    endtask

    task automatic test_reset_mid_frame;
        bit seen;
        seen = 1'b0;
        set_pix(0, 0);
        clear_logs(0);
        hold_ready[0] = 1'b1;
        ready[0]      = 1'b0;
        begin_frame(0, "mid_reset");
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (valid[0]) seen = 1'b1;
        end
        #2;
        rst = 1'b0;
        #1;
        check_outputs_zero(0, "mid_reset");
        repeat (4) @(posedge clk);
        checks++;
        if (ccnt[0] != 0) begin
            errors++;
            $display("FAIL mid_reset_complete got %0d pulses want 0", ccnt[0]);
        end
        @(negedge clk);
        rst           = 1'b1;
        hold_ready[0] = 1'b0;
        rand_ready[0] = 1'b1;
        set_pix(0, 0);
        run_frame(0, "rerun");
        check_frame(0, "rerun");
    endtask

    task automatic test_single_pixel;
        set_pix(2, 1);
        rand_ready[2] = 1'b0;
        run_frame(2, "single");
        check_frame(2, "single");
        checks++;
        if (blog[2][0] !== 8'h01 || blast[2][0] !== 1'b1 || rcnt[2] != 1 || rlog[2][0] != 0) begin
            errors++;
            $display("FAIL single_literal got %h last %b reads %0d want 01 1 1", blog[2][0], blast[2][0], rcnt[2]);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 2; k++) begin
                set_pix(k, 0);
                rand_ready[k] = 1'b1;
                run_frame(k, "random");
                check_frame(k, "random");
            end
        end
    endtask

    task automatic test_back_to_back;
        set_pix(0, 0);
        clear_logs(0);
        rand_ready[0] = 1'b1;
        @(posedge clk); #1;
        src_done   = 1'b1;
        src_stage5 = 1'b1;
        start[0]   = 1'b1;
        wait_complete(0, "b2b_first");
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap busy got %b want 0", busy[0]);
        end
        clear_logs(0);
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart busy got %b want 1", busy[0]);
        end
        @(posedge clk); #1;
        start[0] = 1'b0;
        wait_complete(0, "b2b_second");
        repeat (3) @(posedge clk);
        check_frame(0, "b2b_second");
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        src_done   = 1'b0;
        src_stage5 = 1'b0;
        for (int k = 0; k < NI; k++) begin
            start[k]      = 1'b0;
            ready[k]      = 1'b1;
            hold_ready[k] = 1'b0;
            rand_ready[k] = 1'b0;
            clear_logs(k);
            set_pix(k, 2);
        end
        test_reset;
        test_basic;
        test_gating;
        test_backpressure;
        test_ones_zeros;
        test_reset_mid_frame;
        test_single_pixel;
        test_random;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
